// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and next-PC select encoding for the IF stage.
//   NOP_INSTR  bubble instruction (addi x0,x0,0)
//   RESET_PC   default first fetch address
//   pcsel_e    next-PC source, shared with hazard unit and trace monitor
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSEL_SEQ  = 2'd0,
        PCSEL_JAL  = 2'd1,
        PCSEL_JALR = 2'd2,
        PCSEL_BR   = 2'd3
    } pcsel_e;

endpackage

// File: rtl/fetch_stage_npc_gen.sv
// fetch_stage_npc_gen: combinational next-PC priority mux with word alignment.
//   pc_i                      current fetch PC
//   br_i/br_target_i          taken branch from EX (highest priority)
//   jalr_i/jalr_target_i      JALR from EX
//   jal_i/jal_target_i        JAL from ID
//   npc_o                     next PC, bits [1:0] forced to 00
//   sel_o                     selected source
module fetch_stage_npc_gen
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            br_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] jalr_target_i,
    input  logic            jal_i,
    input  logic [XLEN-1:0] jal_target_i,
    output logic [XLEN-1:0] npc_o,
    output pcsel_e          sel_o
);

    logic [XLEN-1:0] raw;

    always_comb begin
        sel_o = br_i ? PCSEL_BR : jalr_i ? PCSEL_JALR : jal_i ? PCSEL_JAL : PCSEL_SEQ;
        raw   = br_i ? br_target_i : jalr_i ? jalr_target_i : jal_i ? jal_target_i : pc_i + XLEN'(4);
        // Masking both low bits also covers the JALR bit-0 clear.
        npc_o = raw & ~{{(XLEN-2){1'b0}}, 2'b11};
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID boundary for the 5-stage RV32I pipeline.
//   clk, rst_n                  clock, synchronous active-low reset
//   stall_f, stall_d, flush_d   hazard unit controls
//   br_e/jalr_e/jal_d + targets redirect requests
//   imem_addr, imem_rdata       synchronous BRAM (data one cycle after address)
//   pc_f, pc_d, npc_d           fetch PC, ID PC, ID PC + 4
//   instr_d, valid_d            ID instruction and real-instruction flag
//   op_d, fn3_d, fn7_d          decoder field slices of instr_d
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(fetch_stage_pkg::RESET_PC),
    parameter logic [31:0]     NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            br_e,
    input  logic [XLEN-1:0] br_target_e,
    input  logic            jalr_e,
    input  logic [XLEN-1:0] jalr_target_e,
    input  logic            jal_d,
    input  logic [XLEN-1:0] jal_target_d,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] npc_d,
    output logic [31:0]     instr_d,
    output logic            valid_d,
    output logic [6:0]      op_d,
    output logic [2:0]      fn3_d,
    output logic [6:0]      fn7_d
);

    logic [XLEN-1:0] pc_f_q, pc_f_d, pc_d_q, pc_d_d, npc;
    logic            kill_q, kill_d, hold_valid_q, hold_valid_d;
    logic [31:0]     hold_q, hold_d, instr_sel;
    pcsel_e          sel;

    fetch_stage_npc_gen #(.XLEN(XLEN)) u_npc_gen (
        .pc_i          (pc_f_q),
        .br_i          (br_e),
        .br_target_i   (br_target_e),
        .jalr_i        (jalr_e),
        .jalr_target_i (jalr_target_e),
        .jal_i         (jal_d),
        .jal_target_i  (jal_target_d),
        .npc_o         (npc),
        .sel_o         (sel)
    );

    always_comb begin
        // The held word covers the BRAM output moving on while ID is stalled.
        instr_sel    = kill_q ? NOP_INSTR : hold_valid_q ? hold_q : imem_rdata;
        pc_f_d       = (sel != PCSEL_SEQ || !stall_f) ? npc : pc_f_q;
        pc_d_d       = pc_d_q;
        kill_d       = kill_q;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (flush_d) begin
            kill_d       = 1'b1;
            hold_valid_d = 1'b0;
            pc_d_d       = pc_f_q;
        end else if (!stall_d) begin
            kill_d       = 1'b0;
            hold_valid_d = 1'b0;
            pc_d_d       = pc_f_q;
        end else if (!hold_valid_q) begin
            hold_d       = instr_sel;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_f_q       <= RESET_PC;
            pc_d_q       <= '0;
            kill_q       <= 1'b1;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            pc_f_q       <= pc_f_d;
            pc_d_q       <= pc_d_d;
            kill_q       <= kill_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    assign imem_addr = pc_f_q;
    assign pc_f      = pc_f_q;
    assign pc_d      = pc_d_q;
    assign npc_d     = pc_d_q + XLEN'(4);
    assign instr_d   = instr_sel;
    assign valid_d   = ~kill_q;
    assign op_d      = instr_sel[6:0];
    assign fn3_d     = instr_sel[14:12];
    assign fn7_d     = instr_sel[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a BRAM model (word at A = 0x100+A).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall_f, stall_d, flush_d, br_e, jalr_e, jal_d;
    logic [31:0] br_target_e, jalr_target_e, jal_target_d;
    logic [31:0] imem_addr, imem_rdata, pc_f, pc_d, npc_d, instr_d;
    logic        valid_d;
    logic [6:0]  op_d, fn7_d;
    logic [2:0]  fn3_d;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    initial imem_rdata = 32'h0;
    always @(posedge clk) imem_rdata <= 32'h100 + imem_addr;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .br_e          (br_e),
        .br_target_e   (br_target_e),
        .jalr_e        (jalr_e),
        .jalr_target_e (jalr_target_e),
        .jal_d         (jal_d),
        .jal_target_d  (jal_target_d),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc_f          (pc_f),
        .pc_d          (pc_d),
        .npc_d         (npc_d),
        .instr_d       (instr_d),
        .valid_d       (valid_d),
        .op_d          (op_d),
        .fn3_d         (fn3_d),
        .fn7_d         (fn7_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_id(input string tag, input logic [31:0] epc_f, input logic [31:0] epc_d,
                             input logic [31:0] einstr, input logic evalid);
        check({tag, ".pc_f"}, pc_f, epc_f);
        check({tag, ".imem_addr"}, imem_addr, epc_f);
        check({tag, ".pc_d"}, pc_d, epc_d);
        check({tag, ".instr_d"}, instr_d, einstr);
        check({tag, ".valid_d"}, {31'b0, valid_d}, {31'b0, evalid});
    endtask

    initial begin
        rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        br_e = 1'b0; jalr_e = 1'b0; jal_d = 1'b0;
        br_target_e = '0; jalr_target_e = '0; jal_target_d = '0;
        step(); step();
        expect_id("reset", 32'h0, 32'h0, 32'h13, 1'b0);
        check("reset.op_d", {25'b0, op_d}, 32'h13);
        check("reset.fn3_d", {29'b0, fn3_d}, 32'h0);
        check("reset.fn7_d", {25'b0, fn7_d}, 32'h0);
        rst_n = 1'b1;
        step(); expect_id("run0", 32'h4, 32'h0, 32'h100, 1'b1);
        check("run0.npc_d", npc_d, 32'h4);
        step(); expect_id("run1", 32'h8, 32'h4, 32'h104, 1'b1);
        step(); expect_id("run2", 32'hC, 32'h8, 32'h108, 1'b1);
        stall_d = 1'b1; stall_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_id($sformatf("stall%0d", i), 32'hC, 32'h8, 32'h108, 1'b1);
        end
        stall_d = 1'b0; stall_f = 1'b0;
        step(); expect_id("release", 32'h10, 32'hC, 32'h10C, 1'b1);
        step(); expect_id("run3", 32'h14, 32'h10, 32'h110, 1'b1);
        jal_d = 1'b1; jal_target_d = 32'h40; flush_d = 1'b1;
        step(); expect_id("jal_bubble", 32'h40, 32'h14, 32'h13, 1'b0);
        jal_d = 1'b0; flush_d = 1'b0;
        step(); expect_id("jal_tgt", 32'h44, 32'h40, 32'h140, 1'b1);
        check("jal_tgt.npc_d", npc_d, 32'h44);
        br_e = 1'b1; br_target_e = 32'h82; jal_d = 1'b1; jal_target_d = 32'h40; flush_d = 1'b1;
        step(); expect_id("br_wins", 32'h80, 32'h44, 32'h13, 1'b0);
        br_e = 1'b0; jal_d = 1'b0; flush_d = 1'b0;
        step(); expect_id("br_tgt", 32'h84, 32'h80, 32'h180, 1'b1);
        jalr_e = 1'b1; jalr_target_e = 32'h23; stall_f = 1'b1; flush_d = 1'b1;
        step(); expect_id("jalr", 32'h20, 32'h84, 32'h13, 1'b0);
        jalr_e = 1'b0; stall_f = 1'b0; flush_d = 1'b0;
        step(); expect_id("jalr_tgt", 32'h24, 32'h20, 32'h120, 1'b1);
        stall_d = 1'b1; stall_f = 1'b1;
        step(); expect_id("hold0", 32'h24, 32'h20, 32'h120, 1'b1);
        step(); expect_id("hold1", 32'h24, 32'h20, 32'h120, 1'b1);
        flush_d = 1'b1;
        step(); expect_id("flush_stall", 32'h24, 32'h24, 32'h13, 1'b0);
        flush_d = 1'b0; stall_d = 1'b0; stall_f = 1'b0;
        step(); expect_id("post_flush", 32'h28, 32'h24, 32'h124, 1'b1);
        stall_d = 1'b1; stall_f = 1'b1;
        step(); expect_id("pre_rst", 32'h28, 32'h24, 32'h124, 1'b1);
        rst_n = 1'b0;
        step(); expect_id("rst_mid", 32'h0, 32'h0, 32'h13, 1'b0);
        rst_n = 1'b1; stall_d = 1'b0; stall_f = 1'b0;
        step(); expect_id("rst_rel", 32'h4, 32'h0, 32'h100, 1'b1);
        jal_d = 1'b1; jal_target_d = 32'hFFFF_FFFC; flush_d = 1'b1;
        step(); expect_id("wrap_jal", 32'hFFFF_FFFC, 32'h4, 32'h13, 1'b0);
        jal_d = 1'b0; flush_d = 1'b0;
        step(); expect_id("wrap", 32'h0, 32'hFFFF_FFFC, 32'hFC, 1'b1);
        check("wrap.npc_d", npc_d, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
